// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_lock_arbiter
// Brief    : Registered round-robin arbiter with per-requester grant lock,
//            capped at MAX_HOLD consecutive cycles.
// Revision : 1.0 - initial release
// ============================================================================
module rr_lock_arbiter #(
    parameter int N        = 10,
    parameter int LOGN     = $clog2(N),
    parameter int MAX_HOLD = 4,
    parameter int CNTW     = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [LOGN-1:0] gnt_idx,
    output logic            gnt_last
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] c_max_hold = CNTW'(MAX_HOLD);
    localparam logic [LOGN-1:0] c_last_idx = LOGN'(N - 1);

    state_t          r_state;
    logic [LOGN-1:0] r_ptr;
    logic [CNTW-1:0] r_hold;
    logic [N-1:0]    r_gnt;
    logic [LOGN-1:0] r_idx;

    logic [LOGN-1:0] w_winner;
    logic [N-1:0]    w_winner_oh;
    logic            w_any;
    logic            w_extend;

    // Scan from farthest to nearest so the nearest requester after ptr wins;
    // the modulo is an explicit subtract so non-power-of-2 N wraps correctly.
    always_comb begin
        int v_pos;
        v_pos       = 0;
        w_winner    = r_ptr;
        w_winner_oh = '0;
        w_any       = |req;
        for (int k = N; k >= 1; k--) begin
            v_pos = int'(r_ptr) + k;
            if (v_pos >= N) begin
                v_pos = v_pos - N;
            end
            if (req[v_pos]) begin
                w_winner = LOGN'(v_pos);
            end
        end
        w_winner_oh[w_winner] = 1'b1;
    end

    assign w_extend = (r_state == ST_GRANT) && lock[r_ptr] && (r_hold < c_max_hold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= c_last_idx;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= w_winner_oh;
                        r_ptr   <= w_winner;
                        r_idx   <= w_winner;
                        r_hold  <= CNTW'(1);
                    end else begin
                        r_gnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_extend) begin
                        r_hold  <= r_hold + CNTW'(1);
                    end else if (w_any) begin
                        r_gnt   <= w_winner_oh;
                        r_ptr   <= w_winner;
                        r_idx   <= w_winner;
                        r_hold  <= CNTW'(1);
                    end else begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_hold  <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign gnt_vld  = |r_gnt;
    assign gnt_idx  = r_idx;
    assign gnt_last = gnt_vld && !w_extend;

endmodule
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_lock_arbiter
// Brief    : Self-checking bench for rr_lock_arbiter (N=4, MAX_HOLD=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_lock_arbiter;

    localparam int N    = 4;
    localparam int LOGN = 2;
    localparam int MH   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [LOGN-1:0] gnt_idx;
    logic            gnt_last;

    int n_cmp = 0;
    int n_bad = 0;

    rr_lock_arbiter #(.N(N), .LOGN(LOGN), .MAX_HOLD(MH), .CNTW($clog2(MH + 1))) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .gnt      (gnt),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx),
        .gnt_last (gnt_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: who owns the resource, how long it has held it, who went last.
    int m_cur, m_last, m_run, m_idx;

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = -1; m_last = N - 1; m_run = 0; m_idx = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        int w;
        if (m_cur >= 0 && l[m_cur] && m_run < MH) begin
            m_run++;
        end else begin
            w = pick(r);
            if (w >= 0) begin
                m_cur = w; m_last = w; m_idx = w; m_run = 1;
            end else begin
                m_cur = -1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; lock = '0;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_vld", 32'(gnt_vld), 0);
        chk("rst_idx", 32'(gnt_idx), 0);
        chk("rst_last", 32'(gnt_last), 0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]    req;
        logic [N-1:0]    lock;
        logic [N-1:0]    gnt;
        logic            last;
        logic [LOGN-1:0] idx;
    } vec_t;

    vec_t vecs[19];

    initial begin
        rst = 1'b1; req = '0; lock = '0;
        // Outputs observed just after the edge on which the inputs were sampled.
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd3};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1};
        vecs[6]  = '{4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[7]  = '{4'b0011, 4'b0000, 4'b0010, 1'b1, 2'd1};
        vecs[8]  = '{4'b0011, 4'b0001, 4'b0001, 1'b0, 2'd0};
        vecs[9]  = '{4'b0011, 4'b0001, 4'b0001, 1'b0, 2'd0};
        vecs[10] = '{4'b0011, 4'b0001, 4'b0001, 1'b1, 2'd0};
        vecs[11] = '{4'b0011, 4'b0001, 4'b0010, 1'b1, 2'd1};
        vecs[12] = '{4'b0011, 4'b0001, 4'b0001, 1'b0, 2'd0};
        vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[14] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
        vecs[15] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
        vecs[16] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
        vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2};
        vecs[18] = '{4'b1001, 4'b0010, 4'b1000, 1'b1, 2'd3};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            req = vecs[i].req; lock = vecs[i].lock;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_vld", i), 32'(gnt_vld), 32'(|vecs[i].gnt));
            chk($sformatf("vec%0d_idx", i), 32'(gnt_idx), 32'(vecs[i].idx));
            chk($sformatf("vec%0d_last", i), 32'(gnt_last), 32'(vecs[i].last));
        end

        // Asynchronous reset in the middle of a locked hold.
        do_reset();
        @(negedge clk);
        req = 4'b0011; lock = 4'b0001;
        @(posedge clk);
        @(posedge clk); #2;
        chk("hold_gnt", 32'(gnt), 32'h1);
        rst = 1'b1; #1;
        chk("async_gnt", 32'(gnt), 0);
        chk("async_vld", 32'(gnt_vld), 0);
        chk("async_last", 32'(gnt_last), 0);
        @(negedge clk);
        rst = 1'b0; req = 4'b1001; lock = '0;
        @(posedge clk); #1;
        chk("after_rst_gnt", 32'(gnt), 32'h1);
        chk("after_rst_idx", 32'(gnt_idx), 0);
        @(posedge clk); #1;
        chk("after_rst_gnt2", 32'(gnt), 32'h8);

        // Long idle: grant stays off, index remembers the last grantee.
        @(negedge clk);
        req = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("idle%0d_gnt", c), 32'(gnt), 0);
            chk($sformatf("idle%0d_vld", c), 32'(gnt_vld), 0);
        end
        chk("idle_idx", 32'(gnt_idx), 3);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            req  = N'($urandom);
            lock = (c % 50 < 25) ? N'($urandom) : N'($urandom | $urandom);
            #1;
            chk("rnd_gnt", 32'(gnt), (m_cur >= 0) ? (32'h1 << m_cur) : 32'h0);
            chk("rnd_vld", 32'(gnt_vld), 32'(m_cur >= 0));
            chk("rnd_idx", 32'(gnt_idx), 32'(m_idx));
            chk("rnd_last", 32'(gnt_last),
                32'(m_cur >= 0 && !(lock[m_cur] && m_run < MH)));
            model_step(req, lock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
